// File: rtl/lrsc_filter.sv
// LR/SC filter sitting in front of a memory bank's AMO shim: one reservation per core,
// LR becomes a load, SC becomes a store or a locally answered failure.
module lrsc_filter #(
  parameter int AddrMemWidth = 32,
  parameter int DataWidth    = 32,
  parameter int NumCores     = 8,
  localparam int IdWidth     = (NumCores > 1) ? $clog2(NumCores) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_req_i,
  output logic                     in_gnt_o,
  input  logic [AddrMemWidth-1:0]  in_add_i,
  input  logic [3:0]               in_amo_i,
  input  logic                     in_wen_i,
  input  logic [DataWidth-1:0]     in_wdata_i,
  input  logic [DataWidth/8-1:0]   in_be_i,
  input  logic [IdWidth-1:0]       in_id_i,
  output logic [DataWidth-1:0]     in_rdata_o,
  output logic                     in_rvalid_o,
  output logic                     out_req_o,
  input  logic                     out_gnt_i,
  output logic [AddrMemWidth-1:0]  out_add_o,
  output logic [3:0]               out_amo_o,
  output logic                     out_wen_o,
  output logic [DataWidth-1:0]     out_wdata_o,
  output logic [DataWidth/8-1:0]   out_be_o,
  input  logic [DataWidth-1:0]     out_rdata_i
);

  localparam logic [3:0] AmoNone = 4'h0;
  localparam logic [3:0] AmoLr   = 4'hB;
  localparam logic [3:0] AmoSc   = 4'hC;

  function automatic logic [DataWidth-1:0] sc_status(input logic fail);
    return {{(DataWidth-1){1'b0}}, fail};
  endfunction

  logic                    rsv_valid [NumCores];
  logic [AddrMemWidth-1:0] rsv_addr  [NumCores];

  logic is_lr, is_sc, is_amo, is_store;
  logic sc_hit, sc_miss, granted, clears_mem;

  logic vld_p1, sc_resp_p1, sc_fail_p1;

  assign is_lr    = (in_amo_i == AmoLr);
  assign is_sc    = (in_amo_i == AmoSc);
  assign is_amo   = (in_amo_i >= 4'h1) && (in_amo_i <= 4'hA);
  assign is_store = (in_amo_i == AmoNone) && in_wen_i;

  // Reservation lookup of the issuing core; full word address, byte enables ignored.
  always_comb begin
    sc_hit = 1'b0;
    for (int i = 0; i < NumCores; i++) begin
      if (in_id_i == IdWidth'(i) && rsv_valid[i] && rsv_addr[i] == in_add_i) begin
        sc_hit = 1'b1;
      end
    end
  end

  assign sc_miss = is_sc && !sc_hit;

  // A failing SC never reaches the shim and is answered here even if the shim is stalled.
  assign out_req_o   = in_req_i && !sc_miss;
  assign in_gnt_o    = sc_miss ? in_req_i : (in_req_i && out_gnt_i);
  assign out_add_o   = in_add_i;
  assign out_amo_o   = (is_lr || is_sc) ? AmoNone : in_amo_i;
  assign out_wen_o   = is_lr ? 1'b0 : (is_sc ? 1'b1 : in_wen_i);
  assign out_wdata_o = in_wdata_i;
  assign out_be_o    = in_be_i;

  assign granted    = in_gnt_o;
  assign clears_mem = granted && (is_store || is_amo || (is_sc && sc_hit));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumCores; i++) rsv_valid[i] <= 1'b0;
    end else begin
      for (int i = 0; i < NumCores; i++) begin
        if (granted && in_id_i == IdWidth'(i) && is_lr) begin
          rsv_valid[i] <= 1'b1;
        end else if ((granted && in_id_i == IdWidth'(i) && is_sc) ||
                     (clears_mem && rsv_addr[i] == in_add_i)) begin
          rsv_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumCores; i++) begin
      if (granted && in_id_i == IdWidth'(i) && is_lr) rsv_addr[i] <= in_add_i;
    end
  end

  // Stage p1: response cycle following every grant, local or forwarded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1     <= 1'b0;
      sc_resp_p1 <= 1'b0;
    end else begin
      vld_p1     <= granted;
      sc_resp_p1 <= granted && is_sc;
    end
  end

  always_ff @(posedge clk_i) begin
    sc_fail_p1 <= sc_miss;
  end

  assign in_rvalid_o = vld_p1;
  assign in_rdata_o  = sc_resp_p1 ? sc_status(sc_fail_p1) : out_rdata_i;

endmodule

// File: tb/tb_lrsc_filter.sv
// Scoreboard bench for lrsc_filter: directed LR/SC scenarios followed by random traffic
// checked against a reservation-table reference model.
module tb_lrsc_filter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NC = 8;
  localparam int IW = 3;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          in_req_i, in_gnt_o, in_wen_i, in_rvalid_o;
  logic [AW-1:0] in_add_i, out_add_o;
  logic [3:0]    in_amo_i, out_amo_o;
  logic [DW-1:0] in_wdata_i, in_rdata_o, out_wdata_o, out_rdata_i;
  logic [BW-1:0] in_be_i, out_be_o;
  logic [IW-1:0] in_id_i;
  logic          out_req_o, out_gnt_i, out_wen_o;

  lrsc_filter #(.AddrMemWidth(AW), .DataWidth(DW), .NumCores(NC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i), .in_amo_i(in_amo_i),
    .in_wen_i(in_wen_i), .in_wdata_i(in_wdata_i), .in_be_i(in_be_i), .in_id_i(in_id_i),
    .in_rdata_o(in_rdata_o), .in_rvalid_o(in_rvalid_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_add_o(out_add_o), .out_amo_o(out_amo_o),
    .out_wen_o(out_wen_o), .out_wdata_o(out_wdata_o), .out_be_o(out_be_o), .out_rdata_i(out_rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    bit sc;
    bit fail;
  } exp_t;
  exp_t q[$];

  // Reference reservation table
  bit            rv [NC];
  logic [AW-1:0] ra [NC];

  logic [AW-1:0] addr_pool [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int id, input logic [3:0] amo, input logic wen,
                       input logic [AW-1:0] addr, input logic gnt, input logic rst,
                       input logic req);
    bit is_lr, is_sc, hit, miss, e_req, e_gnt, e_wen, writes;
    logic [3:0] e_amo;
    @(posedge clk);
    #1;
    in_req_i    = req;
    in_id_i     = id[IW-1:0];
    in_amo_i    = amo;
    in_wen_i    = wen;
    in_add_i    = addr;
    in_wdata_i  = $urandom;
    in_be_i     = BW'($urandom);
    out_gnt_i   = gnt;
    out_rdata_i = $urandom;
    rst_i       = rst;
    #1;
    is_lr = (amo == 4'hB);
    is_sc = (amo == 4'hC);
    hit   = rv[id] && (ra[id] == addr);
    miss  = is_sc && !hit;
    e_req = req && !miss;
    e_gnt = miss ? req : (req && gnt);
    e_amo = (is_lr || is_sc) ? 4'h0 : amo;
    e_wen = is_lr ? 1'b0 : (is_sc ? 1'b1 : wen);
    chk("out_req", 128'(out_req_o), 128'(e_req));
    chk("in_gnt", 128'(in_gnt_o), 128'(e_gnt));
    chk("out_fields", 128'({out_add_o, out_amo_o, out_wen_o, out_wdata_o, out_be_o}),
        128'({addr, e_amo, e_wen, in_wdata_i, in_be_i}));
    if (rst) begin
      for (int k = 0; k < NC; k++) rv[k] = 1'b0;
    end else if (e_gnt) begin
      q.push_back('{c: cyc, sc: is_sc, fail: miss});
      writes = (amo == 4'h0 && wen) || (amo >= 4'h1 && amo <= 4'hA) || (is_sc && hit);
      if (writes) begin
        for (int k = 0; k < NC; k++) if (ra[k] == addr) rv[k] = 1'b0;
      end
      if (is_sc) rv[id] = 1'b0;
      if (is_lr) begin
        rv[id] = 1'b1;
        ra[id] = addr;
      end
    end
  endtask

  // Response monitor: every grant must be answered exactly one cycle later.
  always @(negedge clk) begin
    bit ev;
    exp_t e;
    logic [DW-1:0] er;
    ev = (q.size() > 0) && (q[0].c == cyc - 1);
    chk("rvalid", 128'(in_rvalid_o), 128'(ev));
    if (ev) begin
      e  = q.pop_front();
      er = e.sc ? DW'(e.fail) : out_rdata_i;
      chk(e.sc ? "sc_status" : "rdata", 128'(in_rdata_o), 128'(er));
    end
  end

  initial begin
    int r, sel;
    logic [3:0] amo;
    addr_pool[0] = 32'h10; addr_pool[1] = 32'h40;
    addr_pool[2] = 32'h44; addr_pool[3] = 32'h80;
    for (int k = 0; k < NC; k++) begin
      rv[k] = 1'b0;
      ra[k] = '0;
    end
    rst_i = 1'b1; in_req_i = 1'b0; in_id_i = '0; in_amo_i = '0; in_wen_i = 1'b0;
    in_add_i = '0; in_wdata_i = '0; in_be_i = '0; out_gnt_i = 1'b0; out_rdata_i = '0;

    issue(0, 4'h0, 0, 32'h0, 0, 1, 0);
    issue(0, 4'h0, 0, 32'h0, 0, 1, 0);
    issue(0, 4'h0, 0, 32'h0, 0, 0, 0);

    // LR then SC by the same core: success, reservation consumed
    issue(0, 4'hB, 0, 32'h40, 1, 0, 1);
    issue(0, 4'hC, 0, 32'h40, 1, 0, 1);
    issue(0, 4'hC, 0, 32'h40, 1, 0, 1);
    // Intervening store by another core breaks the reservation
    issue(0, 4'hB, 0, 32'h40, 1, 0, 1);
    issue(1, 4'h0, 1, 32'h40, 1, 0, 1);
    issue(0, 4'hC, 0, 32'h40, 1, 0, 1);
    // AMO to a different word leaves it intact
    issue(0, 4'hB, 0, 32'h40, 1, 0, 1);
    issue(1, 4'h2, 1, 32'h44, 1, 0, 1);
    issue(0, 4'hC, 0, 32'h40, 1, 0, 1);
    // Two cores reserve the same word; the first SC kills the second
    issue(0, 4'hB, 0, 32'h80, 1, 0, 1);
    issue(1, 4'hB, 0, 32'h80, 1, 0, 1);
    issue(0, 4'hC, 0, 32'h80, 1, 0, 1);
    issue(1, 4'hC, 0, 32'h80, 1, 0, 1);
    // SC with no reservation while the shim is busy
    issue(2, 4'hC, 0, 32'h10, 0, 0, 1);
    // Stalled LR does not reserve
    issue(3, 4'hB, 0, 32'h44, 0, 0, 1);
    issue(3, 4'hC, 0, 32'h44, 1, 0, 1);
    // Reset on the cycle of a grant: no response, reservations dropped
    issue(0, 4'hB, 0, 32'h10, 1, 0, 1);
    issue(4, 4'h0, 0, 32'h20, 1, 1, 1);
    issue(0, 4'hC, 0, 32'h10, 1, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      r   = $urandom_range(0, 7);
      sel = $urandom_range(0, 3);
      case (r)
        0, 1:    amo = 4'h0;
        2:       amo = 4'($urandom_range(1, 10));
        3, 4:    amo = 4'hB;
        default: amo = 4'hC;
      endcase
      issue($urandom_range(0, NC - 1), amo, 1'($urandom), addr_pool[sel],
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0),
            ($urandom_range(0, 7) != 0));
    end

    issue(0, 4'h0, 0, 32'h0, 0, 0, 0);
    issue(0, 4'h0, 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    chk("drain", 128'(q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
